// File: rtl/rpn_pkg.sv
// rpn_pkg: shared encodings for the RPN calculator core.
//   - opcodes (4 bits, 0..11 legal, 12..15 illegal)
//   - response error codes (3 bits)
//   - control FSM state encoding
package rpn_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_MOD    = 4'd4;
  localparam logic [3:0] OP_POP    = 4'd5;
  localparam logic [3:0] OP_DUP    = 4'd6;
  localparam logic [3:0] OP_SWAP   = 4'd7;
  localparam logic [3:0] OP_PUSH   = 4'd8;
  localparam logic [3:0] OP_APPEND = 4'd9;
  localparam logic [3:0] OP_OVER   = 4'd10;
  localparam logic [3:0] OP_CLEAR  = 4'd11;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_DIV_ZERO  = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_WB  = 2'd2
  } state_t;

endpackage

// File: rtl/rpn_divider.sv
// rpn_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, async active-low reset (aborts a running division)
//   start      : load a/b and begin; ignored while not idle by the caller
//   a, b       : dividend, divisor (b != 0 guaranteed by the caller)
//   q, r       : quotient, remainder; valid the cycle after done
//   done       : high during the WIDTH-th (final) iteration cycle
module rpn_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo, rem, den;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   shifted, diff;

  assign shifted = {rem, quo[WIDTH-1]};
  // rem < den always, so a set MSB of diff means shifted < den (restore)
  assign diff    = shifted - {1'b0, den};
  // Flagged on the last iteration so the caller can step to writeback on
  // the same edge that produces the final quotient bit.
  assign done    = busy && (cnt == CW'(1));
  assign q       = quo;
  assign r       = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo  <= '0;
      rem  <= '0;
      den  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= a;
      rem  <= '0;
      den  <= b;
      cnt  <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_core.sv
// rpn_core: RPN calculator core - register stack, ALU, iterative divider.
//   clk, rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_data    : opcode and PUSH/APPEND operand
//   rsp_valid, rsp_err  : one-cycle completion pulse with error code
//   top, size           : TOS (0 when empty) and entry count
//   empty, full         : size == 0 / size == DEPTH
//   err_sticky          : last response was an error
//
// state      | meaning
// ST_IDLE    | accepting commands, single-cycle ops execute on accept
// ST_DIV_RUN | divider iterating on latched NOS/TOS
// ST_DIV_WB  | pop both operands, push quotient or remainder
module rpn_core
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [2:0]       rsp_err,
  output logic [WIDTH-1:0] top,
  output logic [SW-1:0]    size,
  output logic             empty,
  output logic             full,
  output logic             err_sticky
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic             is_mod;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [AW-1:0]    tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0] tos, nos;
  logic             accept, need1, need2, grows, div_op, div_start, div_done;
  logic [2:0]       err;
  logic [SW-1:0]    size_nx;
  logic             w0_en, w1_en;
  logic [AW-1:0]    w0_idx, w1_idx;
  logic [WIDTH-1:0] w0_dat, w1_dat, div_q, div_r;

  assign tos_idx  = AW'(size - SW'(1));
  assign nos_idx  = AW'(size - SW'(2));
  assign push_idx = AW'(size);
  assign tos      = stk[tos_idx];
  assign nos      = stk[nos_idx];
  assign top      = (size == '0) ? '0 : tos;
  assign empty    = (size == '0);
  assign full     = (size == SW'(DEPTH));
  assign accept   = cmd_valid && cmd_ready;

  assign div_op = (cmd_op == OP_DIV) || (cmd_op == OP_MOD);
  assign need2  = (cmd_op <= OP_MOD) || (cmd_op == OP_SWAP) || (cmd_op == OP_OVER);
  assign need1  = (cmd_op == OP_POP) || (cmd_op == OP_DUP) || (cmd_op == OP_APPEND);
  assign grows  = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP) || (cmd_op == OP_OVER);

  always_comb begin
    err = ERR_OK;
    if (cmd_op > OP_CLEAR)                             err = ERR_ILLEGAL;
    else if ((need2 && size < SW'(2)) || (need1 && empty)) err = ERR_UNDERFLOW;
    else if (grows && full)                            err = ERR_OVERFLOW;
    else if (div_op && tos == '0)                      err = ERR_DIV_ZERO;
  end

  assign div_start = accept && (err == ERR_OK) && div_op;

  rpn_divider #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a     (nos),
    .b     (tos),
    .q     (div_q),
    .r     (div_r),
    .done  (div_done)
  );

  // Stack write ports: w0 targets TOS/new slot, w1 targets NOS.
  always_comb begin
    size_nx = size;
    w0_en   = 1'b0;
    w0_idx  = tos_idx;
    w0_dat  = '0;
    w1_en   = 1'b0;
    w1_idx  = nos_idx;
    w1_dat  = '0;
    if (state == ST_DIV_WB) begin
      w1_en   = 1'b1;
      w1_dat  = is_mod ? div_r : div_q;
      size_nx = size - SW'(1);
    end else if (state == ST_IDLE && accept && err == ERR_OK) begin
      case (cmd_op)
        OP_ADD, OP_SUB, OP_MUL: begin
          w1_en   = 1'b1;
          w1_dat  = (cmd_op == OP_ADD) ? nos + tos :
                    (cmd_op == OP_SUB) ? nos - tos : nos * tos;
          size_nx = size - SW'(1);
        end
        OP_POP:   size_nx = size - SW'(1);
        OP_DUP, OP_OVER, OP_PUSH: begin
          w0_en   = 1'b1;
          w0_idx  = push_idx;
          w0_dat  = (cmd_op == OP_DUP) ? tos : (cmd_op == OP_OVER) ? nos : cmd_data;
          size_nx = size + SW'(1);
        end
        OP_SWAP: begin
          w0_en  = 1'b1;
          w0_dat = nos;
          w1_en  = 1'b1;
          w1_dat = tos;
        end
        OP_APPEND: begin
          w0_en  = 1'b1;
          w0_dat = {tos[WIDTH-9:0], cmd_data[7:0]};
        end
        OP_CLEAR: size_nx = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w0_en) stk[w0_idx] <= w0_dat;
    if (w1_en) stk[w1_idx] <= w1_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      size       <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= ERR_OK;
      err_sticky <= 1'b0;
      is_mod     <= 1'b0;
    end else begin
      size      <= size_nx;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            state     <= ST_DIV_RUN;
            cmd_ready <= 1'b0;
            is_mod    <= (cmd_op == OP_MOD);
          end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= err;
            err_sticky <= (err != ERR_OK);
          end
        end
        ST_DIV_RUN: if (div_done) state <= ST_DIV_WB;
        ST_DIV_WB: begin
          state      <= ST_IDLE;
          cmd_ready  <= 1'b1;
          rsp_valid  <= 1'b1;
          rsp_err    <= ERR_OK;
          err_sticky <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_core.sv
// tb_rpn_core: directed self-checking bench for rpn_core (WIDTH=32, DEPTH=4).
module tb_rpn_core;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int SW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic [2:0]    rsp_err;
  logic [W-1:0]  top;
  logic [SW-1:0] size;
  logic          empty, full, err_sticky;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rpn_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .top        (top),
    .size       (size),
    .empty      (empty),
    .full       (full),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Offer one command for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] d);
    int w = 0;
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 1);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Single-cycle op: response must be present right after acceptance.
  task automatic op1(input string tag, input logic [3:0] op, input logic [W-1:0] d,
                     input logic [2:0] exp_err);
    issue(op, d);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_rsp_err"}, {29'd0, rsp_err}, {29'd0, exp_err});
  endtask

  // DIV/MOD: count ready-low cycles and the cycle index of rsp_valid.
  task automatic run_div(input string tag, input logic [3:0] op, input logic [W-1:0] exp_top);
    int low = 0;
    int lat = 1;
    issue(op, '0);
    while (!cmd_ready && lat < 200) begin
      low++;
      if (rsp_valid) chk({tag, "_early_rsp"}, 1, 0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_ready_low_cycles"}, low, W + 1);
    chk({tag, "_latency"}, lat, W + 2);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_rsp_err"}, {29'd0, rsp_err}, 0);
    chk({tag, "_top"}, top, exp_top);
    chk({tag, "_size"}, {29'd0, size}, 1);
    @(posedge clk); #1;
    chk({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 0);
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_size", {29'd0, size}, 0);
    chk("rst_top", top, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_sticky", {31'd0, err_sticky}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic arithmetic and underflow
    op1("push7", 4'd8, 7, 3'd0);
    op1("push5", 4'd8, 5, 3'd0);
    op1("sub", 4'd1, 0, 3'd0);
    chk("sub_top", top, 2);
    chk("sub_size", {29'd0, size}, 1);
    chk("sub_ready", {31'd0, cmd_ready}, 1);
    op1("mul_uf", 4'd2, 0, 3'd1);
    chk("mul_uf_top", top, 2);
    chk("mul_uf_size", {29'd0, size}, 1);
    chk("mul_uf_sticky", {31'd0, err_sticky}, 1);
    op1("pop", 4'd5, 0, 3'd0);
    chk("pop_top", top, 0);
    chk("pop_empty", {31'd0, empty}, 1);
    chk("pop_sticky", {31'd0, err_sticky}, 0);
    op1("pop_uf", 4'd5, 0, 3'd1);

    // append and wrap-around add
    op1("push12", 4'd8, 32'h12, 3'd0);
    op1("app34", 4'd9, 32'hAB34, 3'd0);
    op1("app56", 4'd9, 32'h56, 3'd0);
    chk("append_top", top, 32'h0012_3456);
    op1("pushff", 4'd8, 32'hFFFF_FFFF, 3'd0);
    op1("add", 4'd0, 0, 3'd0);
    chk("add_wrap_top", top, 32'h0012_3455);
    op1("pop2", 4'd5, 0, 3'd0);

    // multi-cycle divide and modulo
    op1("push100", 4'd8, 100, 3'd0);
    op1("push7b", 4'd8, 7, 3'd0);
    run_div("div", 4'd3, 14);
    op1("pop3", 4'd5, 0, 3'd0);
    op1("push100b", 4'd8, 100, 3'd0);
    op1("push7c", 4'd8, 7, 3'd0);
    run_div("mod", 4'd4, 2);

    // divide by zero: immediate error, no busy period
    op1("clr0", 4'd11, 0, 3'd0);
    op1("push9", 4'd8, 9, 3'd0);
    op1("push0", 4'd8, 0, 3'd0);
    op1("div0", 4'd3, 0, 3'd3);
    chk("div0_ready", {31'd0, cmd_ready}, 1);
    chk("div0_size", {29'd0, size}, 2);
    chk("div0_top", top, 0);
    chk("div0_sticky", {31'd0, err_sticky}, 1);

    // fill to DEPTH, overflow, illegal, clear
    op1("clr1", 4'd11, 0, 3'd0);
    chk("clr1_sticky", {31'd0, err_sticky}, 0);
    for (int i = 1; i <= 4; i++) op1("fill", 4'd8, W'(i * 11), 3'd0);
    chk("fill_full", {31'd0, full}, 1);
    op1("push_of", 4'd8, 55, 3'd2);
    chk("of_top", top, 44);
    chk("of_full", {31'd0, full}, 1);
    op1("dup_of", 4'd6, 0, 3'd2);
    op1("illegal", 4'd14, 0, 3'd5);
    chk("illegal_size", {29'd0, size}, 4);
    op1("clr2", 4'd11, 0, 3'd0);
    chk("clr2_size", {29'd0, size}, 0);
    chk("clr2_sticky", {31'd0, err_sticky}, 0);
    op1("clr_empty", 4'd11, 0, 3'd0);

    // back-to-back: cmd_valid held for two cycles pushes twice
    cmd_op = 4'd8; cmd_data = 77; cmd_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_size", {29'd0, size}, 2);
    op1("clr3", 4'd11, 0, 3'd0);

    // reset in the middle of a division
    op1("push50", 4'd8, 50, 3'd0);
    op1("push3", 4'd8, 3, 3'd0);
    issue(4'd3, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, cmd_ready}, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_size", {29'd0, size}, 0);
    chk("arst_top", top, 0);
    chk("arst_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("arst_no_rsp", seen, 0);
    op1("push3b", 4'd8, 3, 3'd0);
    op1("push4", 4'd8, 4, 3'd0);
    op1("swap", 4'd7, 0, 3'd0);
    chk("swap_top", top, 3);
    op1("over", 4'd10, 0, 3'd0);
    chk("over_top", top, 4);
    chk("over_size", {29'd0, size}, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
